// File: rtl/maq_bcd_counter_if.sv
// ---------------------------------------------------------------------------
// maq_bcd_counter_if
// Control and count signals of the two-digit BCD counter.
//   master : drives enable_1hz, inc, dec, load, load_lsd, load_msd;
//            observes maqc_lsd, maqc_msd, carry, borrow, tc_max, tc_min,
//            load_err.
//   slave  : the counter itself (mirror of master).
// ---------------------------------------------------------------------------
interface maq_bcd_counter_if;
    logic       enable_1hz;
    logic       inc;
    logic       dec;
    logic       load;
    logic [3:0] load_lsd;
    logic [3:0] load_msd;
    logic [3:0] maqc_lsd;
    logic [3:0] maqc_msd;
    logic       carry;
    logic       borrow;
    logic       tc_max;
    logic       tc_min;
    logic       load_err;

    modport master (
        output enable_1hz, inc, dec, load, load_lsd, load_msd,
        input  maqc_lsd, maqc_msd, carry, borrow, tc_max, tc_min, load_err
    );

    modport slave (
        input  enable_1hz, inc, dec, load, load_lsd, load_msd,
        output maqc_lsd, maqc_msd, carry, borrow, tc_max, tc_min, load_err
    );
endinterface

// File: rtl/maq_bcd_counter.sv
// ---------------------------------------------------------------------------
// maq_bcd_counter
// Two-digit BCD up/down counter over MIN_VALUE..MIN_VALUE+MODULUS-1 with
// wrap pulses, terminal-count decodes and a range-checked synchronous preset.
// Ports:
//   maqc_clock : sole clock, rising edge
//   reset      : synchronous, active-high; loads RESET_VALUE
//   bus        : maq_bcd_counter_if.slave
//                in : enable_1hz (tick qualifying inc/dec), inc, dec,
//                     load, load_lsd, load_msd (BCD preset digits)
//                out: maqc_lsd/maqc_msd (count digits), carry/borrow
//                     (registered wrap pulses), tc_max/tc_min
//                     (combinational decodes), load_err (registered
//                     pulse on a rejected preset)
// Priority per edge: reset > load > (tick && inc/dec) > hold.
// ---------------------------------------------------------------------------
module maq_bcd_counter #(
    parameter int MODULUS     = 60,
    parameter int MIN_VALUE   = 0,
    parameter int RESET_VALUE = MIN_VALUE
) (
    input  logic              maqc_clock,
    input  logic              reset,
    maq_bcd_counter_if.slave  bus
);

    localparam int MAX_VALUE = MIN_VALUE + MODULUS - 1;

    localparam logic [3:0] MAX_LSD = 4'(MAX_VALUE % 10);
    localparam logic [3:0] MAX_MSD = 4'(MAX_VALUE / 10);
    localparam logic [3:0] MIN_LSD = 4'(MIN_VALUE % 10);
    localparam logic [3:0] MIN_MSD = 4'(MIN_VALUE / 10);
    localparam logic [3:0] RST_LSD = 4'(RESET_VALUE % 10);
    localparam logic [3:0] RST_MSD = 4'(RESET_VALUE / 10);
    localparam logic [7:0] MIN_V8  = 8'(MIN_VALUE);
    localparam logic [7:0] SPAN_V8 = 8'(MODULUS - 1);

    // Elaboration-time parameter sanity.
    if (MODULUS < 2 || MODULUS > 99) begin : g_bad_modulus
        $error("maq_bcd_counter: MODULUS out of range 2..99");
    end
    if (MIN_VALUE < 0 || MIN_VALUE > 1) begin : g_bad_min
        $error("maq_bcd_counter: MIN_VALUE out of range 0..1");
    end
    if (MAX_VALUE > 99) begin : g_bad_max
        $error("maq_bcd_counter: MIN_VALUE+MODULUS-1 exceeds 99");
    end
    if (RESET_VALUE < MIN_VALUE || RESET_VALUE > MAX_VALUE) begin : g_bad_rst
        $error("maq_bcd_counter: RESET_VALUE outside count range");
    end

    logic [3:0] lsd_q, lsd_d;
    logic [3:0] msd_q, msd_d;
    logic       carry_q, carry_d;
    logic       borrow_q, borrow_d;
    logic       load_err_q, load_err_d;

    logic       at_max;
    logic       at_min;
    logic       step_up;
    logic       step_down;
    logic       digits_ok;
    logic [7:0] ld_v;
    logic [7:0] ld_off;
    logic       ld_ok;

    // Terminal decodes straight off the digit registers (zero latency).
    assign at_max = (msd_q == MAX_MSD) && (lsd_q == MAX_LSD);
    assign at_min = (msd_q == MIN_MSD) && (lsd_q == MIN_LSD);

    // inc and dec together cancel; both need the tick.
    assign step_up   = bus.enable_1hz &&  bus.inc && !bus.dec;
    assign step_down = bus.enable_1hz &&  bus.dec && !bus.inc;

    // Preset range check. ld_v is only meaningful when both digits are
    // BCD (max 99). The offset from MIN_VALUE wraps to a large unsigned
    // value for presets below MIN_VALUE, so a single upper-bound compare
    // covers both ends of the range.
    assign digits_ok = (bus.load_lsd <= 4'd9) && (bus.load_msd <= 4'd9);
    assign ld_v      = 8'(bus.load_msd) * 8'd10 + 8'(bus.load_lsd);
    assign ld_off    = ld_v - MIN_V8;
    assign ld_ok     = digits_ok && (ld_off <= SPAN_V8);

    always_comb begin
        lsd_d      = lsd_q;
        msd_d      = msd_q;
        carry_d    = 1'b0;
        borrow_d   = 1'b0;
        load_err_d = 1'b0;

        if (bus.load) begin
            // A rejected preset still owns the cycle: no step happens.
            if (ld_ok) begin
                lsd_d = bus.load_lsd;
                msd_d = bus.load_msd;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (step_up) begin
            if (at_max) begin
                lsd_d   = MIN_LSD;
                msd_d   = MIN_MSD;
                carry_d = 1'b1;
            end else if (lsd_q == 4'd9) begin
                lsd_d = 4'd0;
                msd_d = 4'(msd_q + 4'd1);
            end else begin
                lsd_d = 4'(lsd_q + 4'd1);
            end
        end else if (step_down) begin
            if (at_min) begin
                lsd_d    = MAX_LSD;
                msd_d    = MAX_MSD;
                borrow_d = 1'b1;
            end else if (lsd_q == 4'd0) begin
                lsd_d = 4'd9;
                msd_d = 4'(msd_q - 4'd1);
            end else begin
                lsd_d = 4'(lsd_q - 4'd1);
            end
        end
    end

    // Reset overrides everything, including a wrap computed this cycle,
    // so no stale carry/borrow escapes a reset edge.
    always_ff @(posedge maqc_clock) begin
        if (reset) begin
            lsd_q      <= RST_LSD;
            msd_q      <= RST_MSD;
            carry_q    <= 1'b0;
            borrow_q   <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            lsd_q      <= lsd_d;
            msd_q      <= msd_d;
            carry_q    <= carry_d;
            borrow_q   <= borrow_d;
            load_err_q <= load_err_d;
        end
    end

    assign bus.maqc_lsd = lsd_q;
    assign bus.maqc_msd = msd_q;
    assign bus.carry    = carry_q;
    assign bus.borrow   = borrow_q;
    assign bus.load_err = load_err_q;
    assign bus.tc_max   = at_max;
    assign bus.tc_min   = at_min;

endmodule

// File: tb/tb_maq_bcd_counter.sv
// ---------------------------------------------------------------------------
// tb_maq_bcd_counter
// Two counters share one stimulus stream: a default 00..59 counter (A) and a
// 12-hour 01..12 counter reset to 12 (B). Each is tracked by an integer
// reference model; every cycle all outputs of both are compared.
// ---------------------------------------------------------------------------
module tb_maq_bcd_counter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    maq_bcd_counter_if ifa();
    maq_bcd_counter_if ifb();

    maq_bcd_counter #(.MODULUS(60), .MIN_VALUE(0)) dut_a (
        .maqc_clock (clk),
        .reset      (rst),
        .bus        (ifa)
    );

    maq_bcd_counter #(.MODULUS(12), .MIN_VALUE(1), .RESET_VALUE(12)) dut_b (
        .maqc_clock (clk),
        .reset      (rst),
        .bus        (ifb)
    );

    int checks   = 0;
    int failures = 0;

    // Model state: count value and expected pulse outputs.
    int va, ca, ba, lea;
    int vb, cb, bb, leb;

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    // Next count and pulses from plain integer arithmetic.
    function automatic void mstep(
        input  int modn, input int minv, input int rv, input int v,
        input  int r, input int en, input int i, input int d,
        input  int ld, input int ll, input int lm,
        output int nv, output int c, output int b, output int le);
        int mx;
        int lv;
        mx = minv + modn - 1;
        lv = lm * 10 + ll;
        nv = v; c = 0; b = 0; le = 0;
        if (r != 0) begin
            nv = rv;
        end else if (ld != 0) begin
            if (ll <= 9 && lm <= 9 && lv >= minv && lv <= mx) nv = lv;
            else le = 1;
        end else if (en != 0 && i != 0 && d == 0) begin
            if (v == mx) begin nv = minv; c = 1; end
            else nv = v + 1;
        end else if (en != 0 && d != 0 && i == 0) begin
            if (v == minv) begin nv = mx; b = 1; end
            else nv = v - 1;
        end
    endfunction

    task automatic check_all();
        chk("A.lsd",    8'(ifa.maqc_lsd), 8'(va % 10));
        chk("A.msd",    8'(ifa.maqc_msd), 8'(va / 10));
        chk("A.carry",  8'(ifa.carry),    8'(ca));
        chk("A.borrow", 8'(ifa.borrow),   8'(ba));
        chk("A.lderr",  8'(ifa.load_err), 8'(lea));
        chk("A.tcmax",  8'(ifa.tc_max),   8'(va == 59));
        chk("A.tcmin",  8'(ifa.tc_min),   8'(va == 0));
        chk("B.lsd",    8'(ifb.maqc_lsd), 8'(vb % 10));
        chk("B.msd",    8'(ifb.maqc_msd), 8'(vb / 10));
        chk("B.carry",  8'(ifb.carry),    8'(cb));
        chk("B.borrow", 8'(ifb.borrow),   8'(bb));
        chk("B.lderr",  8'(ifb.load_err), 8'(leb));
        chk("B.tcmax",  8'(ifb.tc_max),   8'(vb == 12));
        chk("B.tcmin",  8'(ifb.tc_min),   8'(vb == 1));
    endtask

    // One clock: drive, advance the models, let the edge happen, compare.
    task automatic cyc(input int r, input int en, input int i, input int d,
                       input int ld, input int ll, input int lm);
        int nv, c, b, le;
        rst = (r != 0);
        ifa.enable_1hz = (en != 0); ifb.enable_1hz = (en != 0);
        ifa.inc  = (i != 0);        ifb.inc  = (i != 0);
        ifa.dec  = (d != 0);        ifb.dec  = (d != 0);
        ifa.load = (ld != 0);       ifb.load = (ld != 0);
        ifa.load_lsd = 4'(ll);      ifb.load_lsd = 4'(ll);
        ifa.load_msd = 4'(lm);      ifb.load_msd = 4'(lm);
        mstep(60, 0, 0,  va, r, en, i, d, ld, ll, lm, nv, c, b, le);
        va = nv; ca = c; ba = b; lea = le;
        mstep(12, 1, 12, vb, r, en, i, d, ld, ll, lm, nv, c, b, le);
        vb = nv; cb = c; bb = b; leb = le;
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        va = 0; vb = 0;
        // Reset: A -> 00, B -> 12.
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);

        // 60 up-ticks: A walks 01..59 then wraps to 00 with carry.
        for (int k = 0; k < 60; k++) cyc(0, 1, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);

        // Presets: 42 accepted by A, 60 and lsd=A rejected.
        cyc(0, 0, 0, 0, 1, 2, 4);
        cyc(0, 0, 0, 0, 1, 0, 6);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 10, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);

        // Hold cases at 59: inc+dec with tick, inc without tick.
        cyc(0, 0, 0, 0, 1, 9, 5);
        cyc(0, 1, 1, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0);

        // Reset coincident with a wrap discards the carry.
        cyc(1, 1, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);

        // Load beats a tick in the same cycle; rejected load suppresses it.
        cyc(0, 0, 0, 0, 1, 9, 5);
        cyc(0, 1, 1, 0, 1, 7, 3);
        cyc(0, 1, 1, 0, 1, 5, 9);

        // From 10: BCD borrow to 09, down to 00, then wrap to 59 w/ borrow.
        cyc(0, 0, 0, 0, 1, 0, 1);
        for (int k = 0; k < 11; k++) cyc(0, 1, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);

        // 12-hour counter: 12 -> 01 with carry, 01 -> 12 with borrow.
        cyc(0, 0, 0, 0, 1, 2, 1);
        cyc(0, 1, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 1);
        cyc(0, 1, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);

        // Randomised traffic.
        for (int k = 0; k < 2000; k++) begin
            int r, en, i, d, ld, ll, lm;
            r  = ($urandom_range(0, 63) == 0) ? 1 : 0;
            ld = ($urandom_range(0, 7) == 0) ? 1 : 0;
            en = ($urandom_range(0, 3) != 0) ? 1 : 0;
            i  = int'($urandom_range(0, 1));
            d  = ($urandom_range(0, 3) == 0) ? 1 : 0;
            if ($urandom_range(0, 1) == 0) d = 1 - i;
            ll = ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 15))
                                             : int'($urandom_range(0, 9));
            lm = ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 15))
                                             : int'($urandom_range(0, 6));
            cyc(r, en, i, d, ld, ll, lm);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/maq_bcd_counter.md
MAQ_BCD_COUNTER -- requirements
Module: maq_bcd_counter

Interface
REQ-001 Parameter MODULUS, default 60; number of distinct count values, legal range 2..99.
REQ-002 Parameter MIN_VALUE, default 0; lowest count value, legal range 0..1 (1 for 12-hour hour counters).
REQ-003 Parameter RESET_VALUE, default MIN_VALUE; count loaded at reset, must lie in MIN_VALUE..MIN_VALUE+MODULUS-1.
REQ-004 The block SHALL expose the following ports:
- maqc_clock  in  1  sole clock, all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- enable_1hz  in  1  one-cycle tick qualifying inc/dec.
- inc  in  1  count-up request.
- dec  in  1  count-down request.
- load  in  1  synchronous preset strobe.
- load_lsd  in  4  BCD units digit for preset.
- load_msd  in  4  BCD tens digit for preset.
- maqc_lsd  out  4  BCD units digit of count.
- maqc_msd  out  4  BCD tens digit of count.
- carry  out  1  registered one-cycle pulse on upward wrap.
- borrow  out  1  registered one-cycle pulse on downward wrap.
- tc_max  out  1  combinational; count equals MAX.
- tc_min  out  1  combinational; count equals MIN_VALUE.
- load_err  out  1  registered one-cycle pulse on rejected load.
REQ-005 The clock is maqc_clock and the reset is reset; there is one clock, and reset is synchronous and active-high.

Function
REQ-006 MAX SHALL equal MIN_VALUE+MODULUS-1; count value V = 10*maqc_msd + maqc_lsd, always in MIN_VALUE..MAX, both digits always 0..9.
REQ-007 Priority per edge SHALL be: reset > load > (enable_1hz && inc/dec) > hold.
REQ-008 Load SHALL be accepted regardless of enable_1hz when both digits are <=9 and 10*load_msd+load_lsd lies in MIN_VALUE..MAX; the count takes the loaded value on that edge.
REQ-009 Rejected load (digit >9 or value out of range) SHALL leave the count unchanged, assert load_err for the next cycle, and suppress any inc/dec in the same cycle.
REQ-010 Step up (enable_1hz && inc && !dec): V<MAX -> V+1 with BCD carry (lsd 9 -> 0, msd+1); V==MAX -> MIN_VALUE and carry=1 next cycle.
REQ-011 Step down (enable_1hz && dec && !inc): V>MIN_VALUE -> V-1 with BCD borrow (lsd 0 -> 9, msd-1); V==MIN_VALUE -> MAX and borrow=1 next cycle.
REQ-012 enable_1hz && inc && dec SHALL hold the count; no carry, no borrow.
REQ-013 inc/dec without enable_1hz SHALL hold the count.
REQ-014 carry, borrow and load_err SHALL be high exactly one cycle after the causing edge and low otherwise; they are never asserted together.
REQ-015 tc_max/tc_min SHALL decode the current registered count with zero latency; both are high only if MODULUS==1, which is illegal.
REQ-016 The count update is single-cycle: new digits visible one edge after the qualifying request.

Reset
REQ-017 On a rising edge with reset=1: maqc_lsd/maqc_msd = RESET_VALUE digits; carry, borrow and load_err = 0; all other inputs ignored.
REQ-018 Reset asserted mid-count or coincident with a wrap SHALL discard the wrap; no carry or borrow pulse follows.
REQ-019 Outputs are undefined before the first reset edge; no asynchronous behaviour exists.

Verification
REQ-020 Defaults, reset, then 60 ticks with inc=1 -> 00,01..59, then 00 with carry=1 one cycle; tc_max high only at 59.
REQ-021 MODULUS=12, MIN_VALUE=1: count 12, tick+inc -> 01 with carry; tick+dec at 01 -> 12 with borrow.
REQ-022 Defaults, load 4/2 (value 42) -> count 42 with no tick; load 6/0 (value 60) -> count unchanged, load_err pulse; load lsd=A -> rejected, load_err.
REQ-023 At 59: tick with inc=dec=1 -> hold 59, no carry; inc=1 without tick -> hold.
REQ-024 At 59: tick+inc coincident with reset=1 -> RESET_VALUE, carry stays 0; load and tick+inc in the same cycle -> loaded value wins.
REQ-025 Count 10, tick+dec -> 09 (BCD borrow), then dec to 00 -> tc_min=1; next tick+dec -> 59 with borrow.
